// File: rtl/iob_fifo_sync_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable registered or FWFT read.
module iob_fifo_sync_prog #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int FWFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              w_en,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_full,
    input  logic              r_en,
    output logic [DATA_W-1:0] r_data,
    output logic              r_valid,
    output logic              r_empty,
    output logic [ADDR_W:0]   level,
    input  logic [ADDR_W:0]   afull_th,
    input  logic [ADDR_W:0]   aempty_th,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int              DEPTH_N = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};

    logic [DATA_W-1:0] mem [DEPTH_N];
    logic [ADDR_W-1:0] w_ptr_q;
    logic [ADDR_W-1:0] r_ptr_q;
    logic [ADDR_W:0]   level_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              w_acc;
    logic              r_acc;

    // A pop on empty is refused even alongside a write, so a word is never
    // read in the cycle it is written. clr suppresses both accepts.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        r_acc = 1'b0;
        w_acc = 1'b0;
        if (!clr) begin
            r_acc = r_en && (level_q != '0);
            w_acc = w_en && ((level_q < DEPTH) || r_acc);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            if (w_acc) w_ptr_q <= w_ptr_q + 1'b1;
            if (r_acc) r_ptr_q <= r_ptr_q + 1'b1;
            if (w_acc && !r_acc) level_q <= level_q + 1'b1;
            else if (r_acc && !w_acc) level_q <= level_q - 1'b1;
            if (w_en && !w_acc) overflow_q  <= 1'b1;
            if (r_en && !r_acc) underflow_q <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_acc) mem[w_ptr_q] <= w_data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data  = mem[r_ptr_q];
            assign r_valid = (level_q != '0);
        end else begin : g_reg
            logic [DATA_W-1:0] r_data_q;
            logic              r_valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else if (clr) begin
                    r_valid_q <= 1'b0;
                end else begin
                    r_valid_q <= r_acc;
                    if (r_acc) r_data_q <= mem[r_ptr_q];
                end
            end

            assign r_data  = r_data_q;
            assign r_valid = r_valid_q;
        end
    endgenerate

    assign level        = level_q;
    assign w_full       = (level_q == DEPTH);
    assign r_empty      = (level_q == '0);
    assign almost_full  = (level_q >= afull_th);
    assign almost_empty = (level_q <= aempty_th);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
